// File: rtl/crc_stream_mc.sv
// crc_stream_mc: multi-channel interleaved streaming CRC engine.
// Each beat's data contribution is computed from a zero state and XOR-reduced
// lane group by lane group through the pipeline registers. The per-channel
// running state is advanced and folded in only at the final stage, so
// back-to-back beats of one channel always see the state left by the
// previous beat without any bubble.
module crc_stream_mc #(
    parameter int                     DWIDTH    = 64,
    parameter int                     CRC_WIDTH = 32,
    parameter logic [CRC_WIDTH-1:0]   CRC_POLY  = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0]   INIT      = '1,
    parameter logic [CRC_WIDTH-1:0]   XOR_OUT   = '1,
    parameter bit                     REFIN     = 1'b1,
    parameter bit                     REFOUT    = 1'b1,
    parameter int                     NUM_CH    = 4,
    parameter int                     PIPE_LVL  = 1,
    localparam int                    NBYTES    = DWIDTH / 8,
    localparam int                    CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DWIDTH-1:0]     s_data,
    input  logic [NBYTES-1:0]     s_keep,
    input  logic                  s_last,
    input  logic [CH_W-1:0]       s_ch,
    input  logic [CRC_WIDTH-1:0]  s_crc_exp,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CRC_WIDTH-1:0]  m_crc,
    output logic [CH_W-1:0]       m_ch,
    output logic                  m_err,
    output logic                  m_bad
);

    localparam int NB_W = $clog2(NBYTES + 1);
    localparam int PR   = (PIPE_LVL > 0) ? PIPE_LVL : 1;

    typedef logic [CRC_WIDTH-1:0] crc_t;

    // One beat travelling down the pipeline; acc holds the data term so far.
    typedef struct packed {
        logic              valid;
        logic              last;
        logic              bad;
        logic [CH_W-1:0]   ch;
        logic [NB_W-1:0]   nb;
        logic [DWIDTH-1:0] data;
        crc_t              exp;
        crc_t              acc;
    } beat_t;

    // Bit-reverse one byte (input reflection).
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Bit-reverse a full CRC word (output reflection).
    function automatic crc_t rev_crc(input crc_t c);
        crc_t r;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = c[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    // Run the first nb bytes through the CRC register starting from st;
    // lanes with sel=0 are fed as zero bytes. Linear in (st, data).
    function automatic crc_t crc_run(input crc_t st, input logic [DWIDTH-1:0] data,
                                     input logic [NB_W-1:0] nb, input logic [NBYTES-1:0] sel);
        crc_t       c;
        crc_t       t;
        logic [7:0] b;
        c = st;
        for (int i = 0; i < NBYTES; i++) begin
            if (i < int'(nb)) begin
                b = sel[i] ? data[8*i +: 8] : 8'h00;
                if (REFIN) begin
                    b = rev8(b);
                end
                t = '0;
                t[CRC_WIDTH-1 -: 8] = b;
                c = c ^ t;
                for (int k = 0; k < 8; k++) begin
                    if (c[CRC_WIDTH-1]) begin
                        c = (c << 1) ^ CRC_POLY;
                    end else begin
                        c = c << 1;
                    end
                end
            end
        end
        return c;
    endfunction

    // Lanes whose data term is folded in at a given stage. With no
    // reduction stages every lane is handled at the final stage.
    function automatic logic [NBYTES-1:0] lane_mask(input int stage);
        logic [NBYTES-1:0] m;
        for (int i = 0; i < NBYTES; i++) begin
            if (PIPE_LVL == 0) begin
                m[i] = (stage == 0) ? 1'b1 : 1'b0;
            end else begin
                m[i] = ((i % PR) == stage) ? 1'b1 : 1'b0;
            end
        end
        return m;
    endfunction

    // One reduction stage: add this stage's lane group to the data term.
    function automatic beat_t stage_step(input beat_t b, input int stage);
        beat_t r;
        r     = b;
        r.acc = b.acc ^ crc_run('0, b.data, b.nb, lane_mask(stage));
        return r;
    endfunction

    logic              en_s;
    logic [NB_W-1:0]   keep_cnt_s;
    logic              keep_ok_s;
    logic [NB_W-1:0]   nb_in_s;
    beat_t             stg_s [0:PIPE_LVL];
    beat_t             stg_r [0:PR-1];
    beat_t             fin_s;
    crc_t              fin_data_s;
    crc_t              fin_next_s;
    crc_t              fin_crc_s;
    crc_t              ch_state_r [0:NUM_CH-1];

    assign en_s    = !(m_valid && !m_ready);
    assign s_ready = en_s;

    // Decode byte count and legality of s_keep (only meaningful on last beat).
    always_comb begin
        keep_cnt_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (s_keep[i]) begin
                keep_cnt_s = keep_cnt_s + NB_W'(1);
            end else begin
                keep_cnt_s = keep_cnt_s;
            end
        end
        keep_ok_s = (s_keep != '0) && ((s_keep & (s_keep + NBYTES'(1))) == '0);
        if (s_last) begin
            nb_in_s = keep_cnt_s;
        end else begin
            nb_in_s = NB_W'(NBYTES);
        end
    end

    assign stg_s[0] = {s_valid && en_s, s_last, s_last && !keep_ok_s, s_ch, nb_in_s,
                       s_data, s_crc_exp, {CRC_WIDTH{1'b0}}};

    for (genvar g = 0; g < PIPE_LVL; g++) begin : g_link
        assign stg_s[g+1] = stg_r[g];
    end

    // Data-reduction pipeline registers; frozen while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PR; s++) begin
                stg_r[s] <= '0;
            end
        end else if (en_s) begin
            for (int s = 0; s < PIPE_LVL; s++) begin
                stg_r[s] <= stage_step(stg_s[s], s);
            end
        end
    end

    // Final stage: fold in the remaining data lanes and the channel state.
    always_comb begin
        fin_s      = stg_s[PIPE_LVL];
        fin_data_s = fin_s.acc ^ crc_run('0, fin_s.data, fin_s.nb, lane_mask(PIPE_LVL));
        fin_next_s = crc_run(ch_state_r[fin_s.ch], '0, fin_s.nb, '0) ^ fin_data_s;
        fin_crc_s  = (REFOUT ? rev_crc(fin_next_s) : fin_next_s) ^ XOR_OUT;
    end

    // Channel state update and registered result output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state_r[c] <= INIT;
            end
            m_valid <= 1'b0;
            m_crc   <= '0;
            m_ch    <= '0;
            m_err   <= 1'b0;
            m_bad   <= 1'b0;
        end else if (en_s) begin
            if (fin_s.valid && fin_s.last) begin
                ch_state_r[fin_s.ch] <= INIT;
                m_valid              <= 1'b1;
                m_ch                 <= fin_s.ch;
                if (fin_s.bad) begin
                    m_crc <= '0;
                    m_err <= 1'b1;
                    m_bad <= 1'b1;
                end else begin
                    m_crc <= fin_crc_s;
                    m_err <= (fin_crc_s != fin_s.exp);
                    m_bad <= 1'b0;
                end
            end else if (fin_s.valid) begin
                ch_state_r[fin_s.ch] <= fin_next_s;
                m_valid              <= 1'b0;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_mc.sv
// Self-checking bench for crc_stream_mc: directed known vectors plus randomized
// interleaved frames checked against a byte-buffer CRC-32 reference model.
module tb_crc_stream_mc;

    localparam int PIPE = 1;
    localparam int NCH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_last, m_ready;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic [1:0]  s_ch;
    logic [31:0] s_crc_exp;
    logic        s_ready, m_valid, m_err, m_bad;
    logic [31:0] m_crc;
    logic [1:0]  m_ch;
    logic        s_ready16, m_valid16, m_err16, m_bad16;
    logic [15:0] m_crc16;
    logic [1:0]  m_ch16;

    always #5 clk = ~clk;

    crc_stream_mc #(.PIPE_LVL(PIPE)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_keep(s_keep), .s_last(s_last), .s_ch(s_ch), .s_crc_exp(s_crc_exp),
        .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_ch(m_ch),
        .m_err(m_err), .m_bad(m_bad)
    );

    crc_stream_mc #(.CRC_WIDTH(16), .CRC_POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
                    .REFIN(1'b0), .REFOUT(1'b0), .PIPE_LVL(PIPE)) dut16 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data),
        .s_keep(s_keep), .s_last(s_last), .s_ch(s_ch), .s_crc_exp(s_crc_exp[15:0]),
        .m_valid(m_valid16), .m_ready(m_ready), .m_crc(m_crc16), .m_ch(m_ch16),
        .m_err(m_err16), .m_bad(m_bad16)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] crc;
        logic        err;
        logic        bad;
    } res_t;

    res_t       exp_q[$];
    res_t       got_q[$];
    logic [7:0] fbuf [0:NCH-1][0:511];
    int         flen [0:NCH-1];
    int         passed = 0;
    int         total  = 0;

    localparam logic [63:0] B0 = 64'h3837363534333231;   // "12345678"
    localparam logic [63:0] B1 = 64'hA5A5A5A5A5A5A539;   // '9' plus junk lanes

    // Reference CRC-32/ISO-HDLC (reflected shift-right form) over the
    // channel's buffered bytes followed by n extra bytes.
    function automatic logic [31:0] ref_crc32(input int ch, input logic [63:0] extra, input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < flen[ch] + n; i++) begin
            b = (i < flen[ch]) ? fbuf[ch][i] : extra[8*(i-flen[ch]) +: 8];
            c = c ^ {24'h000000, b};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Number of bytes for a legal keep, 0 when the keep is illegal.
    function automatic int keep_len(input logic [7:0] k);
        int r;
        r = 0;
        for (int n = 1; n <= 8; n++) begin
            if ({1'b0, k} == ((9'd1 << n) - 9'd1)) r = n;
        end
        return r;
    endfunction

    // Record every completed output handshake.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back({m_ch, m_crc, m_err, m_bad});
    end

    // Present one beat until accepted, then update the reference model.
    task automatic send_beat(input logic [1:0] ch, input logic [63:0] data, input logic [7:0] keep,
                             input logic last, input logic [31:0] expv);
        bit          acc;
        int          n;
        logic [31:0] c;
        s_valid = 1'b1; s_ch = ch; s_data = data; s_keep = keep; s_last = last; s_crc_exp = expv;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL send_beat_timeout ch=%0d s_ready=%b required 1", ch, s_ready);
        end else if (!last) begin
            for (int i = 0; i < 8; i++) fbuf[ch][flen[ch]+i] = data[8*i +: 8];
            flen[ch] += 8;
        end else begin
            n = keep_len(keep);
            if (n == 0) begin
                exp_q.push_back({ch, 32'h00000000, 1'b1, 1'b1});
            end else begin
                c = ref_crc32(ch, data, n);
                exp_q.push_back({ch, c, (c != expv), 1'b0});
            end
            flen[ch] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passed++;
        total++; if (m_crc !== 32'h0) $display("FAIL reset_m_crc got %h want 0", m_crc); else passed++;
        total++; if (m_ch !== 2'd0) $display("FAIL reset_m_ch got %0d want 0", m_ch); else passed++;
        total++; if (m_err !== 1'b0) $display("FAIL reset_m_err got %b want 0", m_err); else passed++;
        total++; if (m_bad !== 1'b0) $display("FAIL reset_m_bad got %b want 0", m_bad); else passed++;
        total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_known_vector();
        int lat;
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        send_beat(2'd0, B0, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd0, B1, 8'h01, 1'b1, 32'hCBF43926);
        lat = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            lat++;
            if (m_valid) break;
        end
        total++; if (lat !== PIPE + 1) $display("FAIL known_latency got %0d want %0d", lat, PIPE + 1); else passed++;
        total++; if (m_crc !== 32'hCBF43926) $display("FAIL known_crc got %h want cbf43926", m_crc); else passed++;
        total++; if (m_err !== 1'b0) $display("FAIL known_err got %b want 0", m_err); else passed++;
        total++; if (m_bad !== 1'b0) $display("FAIL known_bad got %b want 0", m_bad); else passed++;
        total++; if (m_ch !== 2'd0) $display("FAIL known_ch got %0d want 0", m_ch); else passed++;
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 1) $display("FAIL known_count got %0d want 1", got_q.size()); else passed++;
    endtask

    task automatic test_crc16();
        bit seen;
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        send_beat(2'd0, B0, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd0, B1, 8'h01, 1'b1, 32'h0);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = m_valid16;
        end
        total++; if (!seen) $display("FAIL crc16_valid got 0 want 1"); else passed++;
        total++; if (m_crc16 !== 16'h29B1) $display("FAIL crc16_crc got %h want 29b1", m_crc16); else passed++;
        total++; if (m_err16 !== 1'b1) $display("FAIL crc16_err got %b want 1", m_err16); else passed++;
        total++; if (m_bad16 !== 1'b0) $display("FAIL crc16_bad got %b want 0", m_bad16); else passed++;
        total++; if (m_ch16 !== 2'd0) $display("FAIL crc16_ch got %0d want 0", m_ch16); else passed++;
        repeat (4) @(negedge clk);
        total++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0])
            $display("FAIL crc16_crc32_side got n=%0d want %h", got_q.size(), exp_q[0]);
        else passed++;
    endtask

    task automatic test_interleave();
        time t0;
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        t0 = $time;
        send_beat(2'd0, B0, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd1, B0, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd0, B1, 8'h01, 1'b1, 32'hCBF43926);
        send_beat(2'd1, B1, 8'h01, 1'b1, 32'hCBF43926);
        total++; if ($time - t0 !== 40) $display("FAIL interleave_no_bubble got %0t want 40", $time - t0); else passed++;
        for (int t = 0; t < 50 && got_q.size() < 2; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 2) $display("FAIL interleave_count got %0d want 2", got_q.size()); else passed++;
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].ch !== 2'(i) || got_q[i].crc !== 32'hCBF43926 || got_q[i].err !== 1'b0)
                $display("FAIL interleave_res%0d got ch=%0d crc=%h err=%b want ch=%0d crc=cbf43926 err=0",
                         i, got_q[i].ch, got_q[i].crc, got_q[i].err, i);
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [36:0] cap;
        bit          seen;
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        m_ready = 1'b0;
        send_beat(2'd2, {$urandom, $urandom}, 8'hFF, 1'b1, 32'h0);
        send_beat(2'd3, {$urandom, $urandom}, 8'h0F, 1'b1, 32'h0);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = m_valid;
        end
        total++; if (!seen) $display("FAIL stall_valid got 0 want 1"); else passed++;
        cap = {m_valid, m_ch, m_crc, m_err, m_bad};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0 || s_ready16 !== 1'b0)
                $display("FAIL stall_s_ready cyc%0d got %b/%b want 0/0", c, s_ready, s_ready16);
            else passed++;
            total++;
            if ({m_valid, m_ch, m_crc, m_err, m_bad} !== cap)
                $display("FAIL stall_stable cyc%0d got %h want %h", c, {m_valid, m_ch, m_crc, m_err, m_bad}, cap);
            else passed++;
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int t = 0; t < 50 && got_q.size() < 2; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 2) $display("FAIL stall_count got %0d want 2", got_q.size()); else passed++;
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL stall_res%0d got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_bad_keep();
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        send_beat(2'd1, {$urandom, $urandom}, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd1, {$urandom, $urandom}, 8'h05, 1'b1, 32'h0);
        send_beat(2'd1, B0, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd1, B1, 8'h01, 1'b1, 32'hCBF43926);
        for (int t = 0; t < 50 && got_q.size() < 2; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 2) $display("FAIL badkeep_count got %0d want 2", got_q.size()); else passed++;
        if (got_q.size() >= 2) begin
            total++;
            if (got_q[0].bad !== 1'b1 || got_q[0].err !== 1'b1 || got_q[0].crc !== 32'h0)
                $display("FAIL badkeep_flags got bad=%b err=%b crc=%h want 1 1 0", got_q[0].bad, got_q[0].err, got_q[0].crc);
            else passed++;
            total++;
            if (got_q[1].crc !== 32'hCBF43926 || got_q[1].bad !== 1'b0 || got_q[1].err !== 1'b0)
                $display("FAIL badkeep_recover got crc=%h bad=%b err=%b want cbf43926 0 0", got_q[1].crc, got_q[1].bad, got_q[1].err);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        send_beat(2'd0, B0, 8'hFF, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) flen[c] = 0;
        repeat (8) @(negedge clk);
        total++; if (got_q.size() !== 0) $display("FAIL rstmid_no_result got %0d want 0", got_q.size()); else passed++;
        @(posedge clk); #1;
        send_beat(2'd0, B0, 8'hFF, 1'b0, 32'h0);
        send_beat(2'd0, B1, 8'h01, 1'b1, 32'hCBF43926);
        for (int t = 0; t < 50 && got_q.size() < 1; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++;
        if (got_q.size() !== 1 || got_q[0].crc !== 32'hCBF43926)
            $display("FAIL rstmid_after got n=%0d crc=%h want 1 cbf43926", got_q.size(), (got_q.size() > 0) ? got_q[0].crc : 32'h0);
        else passed++;
    endtask

    task automatic test_random();
        int          left [0:NCH-1];
        int          started;
        int          busy;
        int          n;
        bit          done;
        logic [1:0]  ch;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [31:0] expv;
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < NCH; c++) left[c] = 0;
        started = 0;
        done = 1'b0;
        fork
            begin
                busy = 1;
                while (started < 60 || busy > 0) begin
                    ch = 2'($urandom_range(0, NCH - 1));
                    if (left[ch] == 0 && started < 60) begin
                        left[ch] = $urandom_range(1, 4);
                        started++;
                    end
                    if (left[ch] > 0) begin
                        data = {$urandom, $urandom};
                        if (left[ch] == 1) begin
                            n = $urandom_range(1, 8);
                            keep = 8'((9'd1 << n) - 9'd1);
                            if ($urandom_range(0, 7) == 0) keep = 8'($urandom_range(0, 255));
                            expv = ($urandom_range(0, 1) == 1) ? ref_crc32(ch, data, keep_len(keep)) : $urandom;
                            send_beat(ch, data, keep, 1'b1, expv);
                        end else begin
                            send_beat(ch, data, 8'($urandom_range(0, 255)), 1'b0, $urandom);
                        end
                        left[ch]--;
                    end
                    busy = 0;
                    for (int c = 0; c < NCH; c++) busy += left[c];
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        for (int t = 0; t < 300 && got_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (6) @(negedge clk);
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL random_res%0d got ch=%0d crc=%h err=%b bad=%b want ch=%0d crc=%h err=%b bad=%b", i,
                         got_q[i].ch, got_q[i].crc, got_q[i].err, got_q[i].bad,
                         exp_q[i].ch, exp_q[i].crc, exp_q[i].err, exp_q[i].bad);
            else passed++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        s_data = 64'h0; s_keep = 8'h00; s_ch = 2'd0; s_crc_exp = 32'h0;
        for (int c = 0; c < NCH; c++) flen[c] = 0;
        test_reset();
        test_known_vector();
        test_crc16();
        test_interleave();
        test_stall();
        test_bad_keep();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
